// File: rtl/nn_ctrl_pkg.sv
// ============================================================================
// nn_ctrl_pkg : shared FSM encoding and config-register map for nn_ctrl
// Revision    : 1.0
// ============================================================================
`default_nettype none

package nn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } nn_state_e;

  localparam int unsigned NUM_CFG = 9;

  localparam logic [3:0] CFG_W11 = 4'd0;
  localparam logic [3:0] CFG_W12 = 4'd1;
  localparam logic [3:0] CFG_W21 = 4'd2;
  localparam logic [3:0] CFG_W22 = 4'd3;
  localparam logic [3:0] CFG_B1  = 4'd4;
  localparam logic [3:0] CFG_B2  = 4'd5;
  localparam logic [3:0] CFG_W31 = 4'd6;
  localparam logic [3:0] CFG_W32 = 4'd7;
  localparam logic [3:0] CFG_B3  = 4'd8;

  function automatic logic cfg_addr_valid(input logic [3:0] addr);
    return (addr <= CFG_B3);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nn_cfg_regs.sv
// ============================================================================
// nn_cfg_regs : weight/bias register file with idle-only write acceptance
// Revision    : 1.0
// ============================================================================
`default_nettype none

module nn_cfg_regs
  import nn_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 wr_allow,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [W-1:0]         cfg_wdata,
  output logic                 cfg_err,
  output logic [NUM_CFG*W-1:0] weights
);

  logic [W-1:0] w_q [NUM_CFG];
  logic [W-1:0] w_d [NUM_CFG];
  logic         cfg_err_q;
  logic         cfg_err_d;

  // Out-of-range addresses while idle are dropped without raising an error.
  always_comb begin
    w_d       = w_q;
    cfg_err_d = cfg_we && !wr_allow;
    if (cfg_we && wr_allow && cfg_addr_valid(cfg_addr)) begin
      for (int i = 0; i < int'(NUM_CFG); i++) begin
        if (cfg_addr == 4'(i)) begin
          w_d[i] = cfg_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < int'(NUM_CFG); i++) begin
        w_q[i] <= '0;
      end
      cfg_err_q <= 1'b0;
    end else begin
      w_q       <= w_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  for (genvar gi = 0; gi < int'(NUM_CFG); gi++) begin : g_pack
    assign weights[gi*W +: W] = w_q[gi];
  end

  assign cfg_err = cfg_err_q;

endmodule

`default_nettype wire

// File: rtl/nn_ctrl.sv
// ============================================================================
// nn_ctrl : request/settle/result sequencer for a small FP network datapath
//           Optional NN_CTRL_PERF_EN adds a 16-bit completion counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nn_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int exp_width     = 8,
  parameter int mant_width    = 24,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                rst_l,
  input  logic                                cfg_we,
  input  logic [3:0]                          cfg_addr,
  input  logic [exp_width+mant_width-1:0]     cfg_wdata,
  output logic                                cfg_err,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [exp_width+mant_width-1:0]     in_a,
  input  logic [exp_width+mant_width-1:0]     in_b,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [exp_width+mant_width-1:0]     out_data,
  output logic [4:0]                          out_exc,
  output logic [exp_width+mant_width-1:0]     nn_a,
  output logic [exp_width+mant_width-1:0]     nn_b,
  output logic [9*(exp_width+mant_width)-1:0] nn_w,
  input  logic [exp_width+mant_width-1:0]     nn_result,
  input  logic [4:0]                          nn_exc,
  output logic                                busy
`ifdef NN_CTRL_PERF_EN
  ,
  output logic [15:0]                         perf_count
`endif
);

  localparam int         W        = exp_width + mant_width;
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  nn_state_e    state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [4:0]   acc_q, acc_d;
  logic [4:0]   out_exc_q, out_exc_d;
  logic [W-1:0] nn_a_q, nn_a_d;
  logic [W-1:0] nn_b_q, nn_b_d;
  logic [W-1:0] out_data_q, out_data_d;

  nn_cfg_regs #(
    .W (W)
  ) u_cfg_regs (
    .clk       (clk),
    .rst_l     (rst_l),
    .wr_allow  (state_q == ST_IDLE),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_err   (cfg_err),
    .weights   (nn_w)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)      state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == 8'd0) state_d = ST_DONE;
      ST_DONE: if (out_ready)     state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Operands are only loaded on acceptance, so they stay frozen until IDLE.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    nn_a_d     = nn_a_q;
    nn_b_d     = nn_b_q;
    out_data_d = out_data_q;
    out_exc_d  = out_exc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          nn_a_d = in_a;
          nn_b_d = in_b;
          cnt_d  = CNT_LOAD;
          acc_d  = 5'd0;
        end
      end
      ST_WAIT: begin
        acc_d = acc_q | nn_exc;
        if (cnt_q == 8'd0) begin
          out_data_d = nn_result;
          out_exc_d  = acc_q | nn_exc;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_q      <= 8'd0;
      acc_q      <= 5'd0;
      nn_a_q     <= '0;
      nn_b_q     <= '0;
      out_data_q <= '0;
      out_exc_q  <= 5'd0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      nn_a_q     <= nn_a_d;
      nn_b_q     <= nn_b_d;
      out_data_q <= out_data_d;
      out_exc_q  <= out_exc_d;
    end
  end

  assign nn_a     = nn_a_q;
  assign nn_b     = nn_b_q;
  assign out_data = out_data_q;
  assign out_exc  = out_exc_q;

`ifdef NN_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (out_valid && out_ready) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      perf_q <= 16'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_count = perf_q;
`endif

endmodule

`default_nettype wire
